cdc_handshake_tx: RTL

//  Source-domain end of a toggle req/ack CDC handshake. Accepts words on a

---
 rtl/cdc_handshake_tx.sv | 133 +++++++++++++
 1 files changed

// File: rtl/cdc_handshake_tx.sv
// Source-domain side of a toggle req/ack CDC handshake: latches one word, flips tx_req, waits for
// the synchronised rx_ack to match. Optional one-entry skid buffer: CDC_HANDSHAKE_TX_SKID_EN.
module cdc_handshake_tx #(
  parameter int unsigned DW = 8,
  parameter int unsigned W  = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic [DW-1:0] tx_data,
  output logic          tx_req,
  input  logic          rx_ack,
  output logic          busy
);

  if (W < 2) begin : g_bad_depth
    $fatal(1, "cdc_handshake_tx: W must be greater than 1");
  end

  typedef enum logic [1:0] {StIdle, StLoad, StWait} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] tx_data_q, tx_data_d;
  logic          tx_req_q, tx_req_d;
  logic [W-1:0]  ack_sync_q;
  logic          ack_s;
  logic          accept;

`ifdef CDC_HANDSHAKE_TX_SKID_EN
  logic [DW-1:0] skid_data_q, skid_data_d;
  logic          skid_full_q, skid_full_d;

  assign in_ready = (state_q == StIdle) | ~skid_full_q;
`else
  assign in_ready = (state_q == StIdle);
`endif

  assign accept  = in_valid & in_ready;
  assign ack_s   = ack_sync_q[W-1];
  assign tx_data = tx_data_q;
  assign tx_req  = tx_req_q;
  assign busy    = (state_q != StIdle);

  // rx_ack is asynchronous; only the last stage of this chain is ever used.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[W-2:0], rx_ack};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      tx_data_q <= '0;
      tx_req_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      tx_req_q  <= tx_req_d;
    end
  end

`ifdef CDC_HANDSHAKE_TX_SKID_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_data_q <= '0;
      skid_full_q <= 1'b0;
    end else begin
      skid_data_q <= skid_data_d;
      skid_full_q <= skid_full_d;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    tx_req_d  = tx_req_q;
`ifdef CDC_HANDSHAKE_TX_SKID_EN
    skid_data_d = skid_data_q;
    skid_full_d = skid_full_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          tx_data_d = in_data;
          state_d   = StLoad;
        end
      end
      // tx_data was written last cycle, so it is settled before the request flips.
      StLoad: begin
        tx_req_d = ~tx_req_q;
        state_d  = StWait;
`ifdef CDC_HANDSHAKE_TX_SKID_EN
        if (accept) begin
          skid_data_d = in_data;
          skid_full_d = 1'b1;
        end
`endif
      end
      StWait: begin
        if (ack_s == tx_req_q) begin
`ifdef CDC_HANDSHAKE_TX_SKID_EN
          if (skid_full_q) begin
            tx_data_d   = skid_data_q;
            skid_full_d = 1'b0;
            state_d     = StLoad;
          end else if (accept) begin
            tx_data_d = in_data;
            state_d   = StLoad;
          end else begin
            state_d = StIdle;
          end
`else
          state_d = StIdle;
`endif
        end
`ifdef CDC_HANDSHAKE_TX_SKID_EN
        else if (accept) begin
          skid_data_d = in_data;
          skid_full_d = 1'b1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

endmodule
